// File: rtl/cd_rx_drain.sv
// Drains frames from the RX RAM into a byte stream, one 32-bit word at a time.
// Handles error-frame dropping, flush of the whole RAM, and the RAM refresh delay.
module cd_rx_drain #(
  parameter bit LEN_PLUS1 = 1'b1,
  parameter bit DROP_ERR  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic        unread,
  input  logic [7:0]  rd_len,
  input  logic        rd_err,
  input  logic [31:0] rd_word,
  output logic [5:0]  rd_addr,
  output logic        rd_en,
  output logic        rd_done,
  output logic        rd_done_all,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic        out_err,
  output logic        out_abort,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [2:0] {IDLE, SETTLE, FETCH, WAIT, SEND, DONE} state_t;

  state_t      state, state_nx;
  logic [7:0]  byte_idx, byte_idx_nx;
  logic [7:0]  last_idx, last_idx_nx;
  logic [7:0]  drop_cnt_nx;
  logic        frame_err, frame_err_nx;
  logic        settle_cnt, settle_cnt_nx;
  logic        abort_nx;
  logic [31:0] hold, hold_nx;
  logic [7:0]  hold_byte;
  logic [7:0]  last_in;
  logic        len_zero;
  logic        drop_now;
  logic        is_last;

  // The frame is tracked by its last byte index, so a 256-byte frame fits in 8 bits.
  assign len_zero = !LEN_PLUS1 && (rd_len == 8'd0);
  assign last_in  = LEN_PLUS1 ? rd_len : (rd_len - 8'd1);
  assign drop_now = rd_err && DROP_ERR;
  assign is_last  = (byte_idx == last_idx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      byte_idx    <= 8'd0;
      last_idx    <= 8'd0;
      frame_err   <= 1'b0;
      settle_cnt  <= 1'b0;
      hold        <= 32'd0;
      drop_cnt    <= 8'd0;
      rd_done_all <= 1'b0;
      out_abort   <= 1'b0;
    end else begin
      state       <= state_nx;
      byte_idx    <= byte_idx_nx;
      last_idx    <= last_idx_nx;
      frame_err   <= frame_err_nx;
      settle_cnt  <= settle_cnt_nx;
      hold        <= hold_nx;
      drop_cnt    <= drop_cnt_nx;
      rd_done_all <= flush;
      out_abort   <= abort_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    byte_idx_nx   = byte_idx;
    last_idx_nx   = last_idx;
    frame_err_nx  = frame_err;
    settle_cnt_nx = settle_cnt;
    hold_nx       = hold;
    drop_cnt_nx   = drop_cnt;
    abort_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (en && unread) begin
          last_idx_nx  = last_in;
          frame_err_nx = rd_err;
          byte_idx_nx  = 8'd0;
          if (drop_now || len_zero) begin
            state_nx = DONE;
            if (drop_now) drop_cnt_nx = drop_cnt + 8'd1;
          end else begin
            state_nx = FETCH;
          end
        end
      end
      FETCH: state_nx = WAIT;
      WAIT: begin
        hold_nx  = rd_word;
        state_nx = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (is_last) begin
            state_nx = DONE;
          end else begin
            byte_idx_nx = byte_idx + 8'd1;
            if (byte_idx[1:0] == 2'd3) state_nx = FETCH;
          end
        end
      end
      DONE: begin
        settle_cnt_nx = 1'b0;
        state_nx      = SETTLE;
      end
      SETTLE: begin
        // The RAM needs two cycles to refresh unread/rd_len after a release.
        if (settle_cnt) state_nx = IDLE;
        else            settle_cnt_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx      = SETTLE;
      settle_cnt_nx = 1'b0;
      drop_cnt_nx   = drop_cnt;
      abort_nx      = (state == FETCH) || (state == WAIT) ||
                      ((state == SEND) && !(out_ready && is_last));
    end
  end

  always_comb begin
    hold_byte = 8'd0;
    case (byte_idx[1:0])
      2'd0: hold_byte = hold[7:0];
      2'd1: hold_byte = hold[15:8];
      2'd2: hold_byte = hold[23:16];
      2'd3: hold_byte = hold[31:24];
      default: hold_byte = 8'd0;
    endcase
  end

  assign rd_addr   = byte_idx[7:2];
  assign rd_en     = (state == FETCH);
  assign rd_done   = (state == DONE) && !flush;
  assign out_valid = (state == SEND);
  assign out_byte  = out_valid ? hold_byte : 8'd0;
  assign out_first = out_valid && (byte_idx == 8'd0);
  assign out_last  = out_valid && is_last;
  assign out_err   = out_valid && frame_err;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cd_rx_drain.sv
// Directed bench for cd_rx_drain: a default instance plus a forwarding
// (DROP_ERR=0) instance, both fed from one small RAM model.
module tb_cd_rx_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, en_f, flush, unread, rd_err, out_ready;
  logic [7:0]  rd_len;
  logic [31:0] rd_word, rd_word_f;
  logic [5:0]  rd_addr, rd_addr_f;
  logic        rd_en, rd_en_f, rd_done, rd_done_f, rd_done_all, rd_done_all_f;
  logic [7:0]  out_byte, out_byte_f, drop_cnt, drop_cnt_f;
  logic        out_valid, out_valid_f, out_first, out_first_f, out_last, out_last_f;
  logic        out_err, out_err_f, out_abort, out_abort_f, busy, busy_f;

  logic [31:0] mem [64];
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] got_b [$];
  bit got_f [$];
  bit got_l [$];
  bit got_e [$];
  int addrs [$];
  int n_done, n_all, n_abort, n_rden, n_valid, unstable, done_cyc;

  cd_rx_drain dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .unread(unread),
    .rd_len(rd_len), .rd_err(rd_err), .rd_word(rd_word), .rd_addr(rd_addr),
    .rd_en(rd_en), .rd_done(rd_done), .rd_done_all(rd_done_all),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .out_err(out_err),
    .out_abort(out_abort), .busy(busy), .drop_cnt(drop_cnt)
  );

  cd_rx_drain #(.LEN_PLUS1(1'b1), .DROP_ERR(1'b0)) dut_f (
    .clk(clk), .reset(reset), .en(en_f), .flush(flush), .unread(unread),
    .rd_len(rd_len), .rd_err(rd_err), .rd_word(rd_word_f), .rd_addr(rd_addr_f),
    .rd_en(rd_en_f), .rd_done(rd_done_f), .rd_done_all(rd_done_all_f),
    .out_byte(out_byte_f), .out_valid(out_valid_f), .out_ready(out_ready),
    .out_first(out_first_f), .out_last(out_last_f), .out_err(out_err_f),
    .out_abort(out_abort_f), .busy(busy_f), .drop_cnt(drop_cnt_f)
  );

  // RAM model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en)   rd_word   <= mem[rd_addr];
    if (rd_en_f) rd_word_f <= mem[rd_addr_f];
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Presents one frame and records the stream until rd_done or the budget runs out.
  task automatic run_frame(input bit use_f, input bit toggle, input int budget);
    logic v, f, l, e, rdn, dn, all, ab;
    logic pf, pl, pe;
    logic [7:0] b, pb;
    logic [5:0] a;
    bit stalled;
    got_b.delete(); got_f.delete(); got_l.delete(); got_e.delete(); addrs.delete();
    n_done = 0; n_all = 0; n_abort = 0; n_rden = 0; n_valid = 0; unstable = 0;
    done_cyc = -1; stalled = 1'b0;
    pb = 8'd0; pf = 1'b0; pl = 1'b0; pe = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == 0) unread = 1'b1;
      out_ready = toggle ? ((c % 2) == 0) : 1'b1;
      #1;
      v   = use_f ? out_valid_f   : out_valid;
      b   = use_f ? out_byte_f    : out_byte;
      f   = use_f ? out_first_f   : out_first;
      l   = use_f ? out_last_f    : out_last;
      e   = use_f ? out_err_f     : out_err;
      rdn = use_f ? rd_en_f       : rd_en;
      a   = use_f ? rd_addr_f     : rd_addr;
      dn  = use_f ? rd_done_f     : rd_done;
      all = use_f ? rd_done_all_f : rd_done_all;
      ab  = use_f ? out_abort_f   : out_abort;
      if (stalled && (!v || b !== pb || f !== pf || l !== pl || e !== pe)) unstable++;
      stalled = v && !out_ready;
      pb = b; pf = f; pl = l; pe = e;
      if (v) n_valid++;
      if (v && out_ready) begin
        got_b.push_back(b); got_f.push_back(f); got_l.push_back(l); got_e.push_back(e);
      end
      if (rdn) begin n_rden++; addrs.push_back(int'(a)); end
      if (all) n_all++;
      if (ab) n_abort++;
      if (dn) begin n_done++; done_cyc = c; break; end
    end
    unread = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    vectors++;
    if ({rd_addr, rd_en, rd_done, rd_done_all, out_byte, out_valid, out_first, out_last,
         out_err, out_abort, busy, drop_cnt} !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got addr=%h en=%b done=%b all=%b byte=%h v=%b busy=%b drop=%h, expected all zero",
               rd_addr, rd_en, rd_done, rd_done_all, out_byte, out_valid, busy, drop_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, rd_done_all, out_abort} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_release: got busy/all/abort=%b, expected 000", {busy, rd_done_all, out_abort});
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [5];
    logic [9:0] act, exp;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    mem[0] = 32'h44332211; mem[1] = 32'h000000AA;
    rd_len = 8'd4; rd_err = 1'b0;
    run_frame(1'b0, 1'b0, 40);
    idle(3);
    for (int k = 0; k < 5; k++) begin
      act = (k < got_b.size()) ? {got_b[k], got_f[k], got_l[k]} : 10'h3FF;
      exp = {exp_b[k], k == 0, k == 4};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL basic_byte%0d: got byte/first/last %h, expected %h", k, act, exp);
      end
    end
    vectors++;
    if (got_b.size() != 5 || n_done != 1 || done_cyc != 10 || n_all != 0) begin
      miscompares++;
      $display("[TB] FAIL basic_frame: got bytes=%0d done=%0d done_cyc=%0d all=%0d, expected 5 1 10 0",
               got_b.size(), n_done, done_cyc, n_all);
    end
    vectors++;
    if (n_rden != 2 || addrs.size() != 2 || addrs[0] != 0 || addrs[1] != 1) begin
      miscompares++;
      $display("[TB] FAIL basic_addr: got %0d reads, expected 2 reads at addr 0 then 1", n_rden);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp_b [5];
    logic [9:0] act, exp;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    mem[0] = 32'h44332211; mem[1] = 32'h000000AA;
    rd_len = 8'd4; rd_err = 1'b0;
    run_frame(1'b0, 1'b1, 60);
    idle(3);
    for (int k = 0; k < 5; k++) begin
      act = (k < got_b.size()) ? {got_b[k], got_f[k], got_l[k]} : 10'h3FF;
      exp = {exp_b[k], k == 0, k == 4};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL stall_byte%0d: got byte/first/last %h, expected %h", k, act, exp);
      end
    end
    vectors++;
    if (unstable != 0 || got_b.size() != 5 || n_done != 1 || done_cyc != 15) begin
      miscompares++;
      $display("[TB] FAIL stall_frame: got unstable=%0d bytes=%0d done=%0d done_cyc=%0d, expected 0 5 1 15",
               unstable, got_b.size(), n_done, done_cyc);
    end
  endtask

  task automatic test_drop();
    rd_len = 8'd9; rd_err = 1'b1;
    run_frame(1'b0, 1'b0, 20);
    idle(3);
    rd_err = 1'b0;
    vectors++;
    if (n_valid != 0 || n_rden != 0 || n_done != 1 || done_cyc != 1) begin
      miscompares++;
      $display("[TB] FAIL drop_frame: got valid=%0d rden=%0d done=%0d done_cyc=%0d, expected 0 0 1 1",
               n_valid, n_rden, n_done, done_cyc);
    end
    vectors++;
    if (drop_cnt !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL drop_cnt: got %0d, expected 1", drop_cnt);
    end
  endtask

  task automatic test_forward();
    logic [10:0] act, exp;
    en = 1'b0; en_f = 1'b1;
    mem[0] = 32'h04030201; mem[1] = 32'h08070605; mem[2] = 32'h00000A09;
    rd_len = 8'd9; rd_err = 1'b1;
    run_frame(1'b1, 1'b0, 60);
    idle(3);
    en = 1'b1; en_f = 1'b0; rd_err = 1'b0;
    for (int k = 0; k < 10; k++) begin
      act = (k < got_b.size()) ? {got_b[k], got_f[k], got_l[k], got_e[k]} : 11'h7FF;
      exp = {8'(k + 1), k == 0, k == 9, 1'b1};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("[TB] FAIL fwd_byte%0d: got byte/first/last/err %h, expected %h", k, act, exp);
      end
    end
    vectors++;
    if (got_b.size() != 10 || n_done != 1 || done_cyc != 17 || drop_cnt_f !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL fwd_frame: got bytes=%0d done=%0d done_cyc=%0d drop=%0d, expected 10 1 17 0",
               got_b.size(), n_done, done_cyc, drop_cnt_f);
    end
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    vectors++;
    if ({rd_done_all, out_abort, busy, rd_done} !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL flush_idle: got all/abort/busy/done=%b, expected 1010",
               {rd_done_all, out_abort, busy, rd_done});
    end
    idle(3);
  endtask

  task automatic test_flush_mid();
    logic v_at [12], all_at [12], ab_at [12], busy_at [12];
    int xfers, dn, alls, abs_n;
    xfers = 0; dn = 0; alls = 0; abs_n = 0;
    mem[0] = 32'h33221100; mem[1] = 32'h77665544;
    rd_len = 8'd7; rd_err = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) unread = 1'b1;
      if (c == 5) unread = 1'b0;
      flush = (c == 5);
      out_ready = (c != 5);
      #1;
      v_at[c] = out_valid; all_at[c] = rd_done_all; ab_at[c] = out_abort; busy_at[c] = busy;
      if (out_valid && out_ready) xfers++;
      if (rd_done) dn++;
      if (rd_done_all) alls++;
      if (out_abort) abs_n++;
    end
    out_ready = 1'b1;
    vectors++;
    if (xfers != 2 || v_at[6] !== 1'b0 || all_at[6] !== 1'b1 || ab_at[6] !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_mid_pulse: got xfers=%0d valid=%b all=%b abort=%b, expected 2 0 1 1",
               xfers, v_at[6], all_at[6], ab_at[6]);
    end
    vectors++;
    if (alls != 1 || abs_n != 1 || dn != 0) begin
      miscompares++;
      $display("[TB] FAIL flush_mid_counts: got all=%0d abort=%0d done=%0d, expected 1 1 0", alls, abs_n, dn);
    end
    vectors++;
    if (busy_at[7] !== 1'b1 || busy_at[8] !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_mid_busy: got busy c7=%b c8=%b, expected 1 0", busy_at[7], busy_at[8]);
    end
  endtask

  task automatic test_flush_last();
    logic [7:0] xb;
    logic all4, ab4, v4;
    int xfers, dn;
    xfers = 0; dn = 0; xb = 8'h00; all4 = 1'b0; ab4 = 1'b1; v4 = 1'b1;
    mem[0] = 32'h000000C3;
    rd_len = 8'd0; rd_err = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) unread = 1'b1;
      if (c == 3) unread = 1'b0;
      flush = (c == 3);
      #1;
      if (out_valid && out_ready) begin xfers++; xb = out_byte; end
      if (rd_done) dn++;
      if (c == 4) begin all4 = rd_done_all; ab4 = out_abort; v4 = out_valid; end
    end
    vectors++;
    if (xfers != 1 || xb !== 8'hC3 || dn != 0) begin
      miscompares++;
      $display("[TB] FAIL flush_last_xfer: got xfers=%0d byte=%h done=%0d, expected 1 c3 0", xfers, xb, dn);
    end
    vectors++;
    if ({all4, ab4, v4} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL flush_last_pulse: got all/abort/valid=%b, expected 100", {all4, ab4, v4});
    end
  endtask

  task automatic test_back_to_back();
    int dn, d1, r2, idle_between, k2, bad, bad_idx, f2_rden, max_addr, f1_cnt;
    logic [7:0] f1_byte, bad_byte;
    dn = 0; d1 = -1; r2 = -1; idle_between = 0; k2 = 0; bad = 0; bad_idx = -1;
    f2_rden = 0; max_addr = -1; f1_cnt = 0; f1_byte = 8'h00; bad_byte = 8'h00;
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 4; j++)
        mem[i][8*j +: 8] = 8'(4 * i + j) ^ 8'h5A;
    rd_len = 8'd0; rd_err = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c == 0) unread = 1'b1;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        if (dn == 0) begin
          f1_cnt++; f1_byte = out_byte;
        end else begin
          if (out_byte !== (8'(k2) ^ 8'h5A) || out_first !== (k2 == 0) || out_last !== (k2 == 255)) begin
            bad++;
            if (bad_idx < 0) begin bad_idx = k2; bad_byte = out_byte; end
          end
          k2++;
        end
      end
      if (rd_en && dn == 1) begin
        f2_rden++;
        if (r2 < 0) r2 = c;
        if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      end
      if (!busy && dn == 1) idle_between++;
      if (rd_done) begin
        dn++;
        if (dn == 1) begin d1 = c; rd_len = 8'd255; end
        else unread = 1'b0;
      end
      if (dn == 2) break;
    end
    unread = 1'b0;
    idle(3);
    vectors++;
    if (dn != 2 || f1_cnt != 1 || f1_byte !== 8'h5A) begin
      miscompares++;
      $display("[TB] FAIL b2b_frame1: got done=%0d bytes=%0d byte=%h, expected 2 1 5a", dn, f1_cnt, f1_byte);
    end
    vectors++;
    if (k2 != 256 || bad != 0) begin
      miscompares++;
      $display("[TB] FAIL b2b_frame2: got bytes=%0d bad=%0d first_bad_idx=%0d byte=%h, expected 256 0",
               k2, bad, bad_idx, bad_byte);
    end
    vectors++;
    if (r2 - d1 != 4 || idle_between != 1) begin
      miscompares++;
      $display("[TB] FAIL b2b_settle: got done_to_fetch=%0d idle=%0d, expected 4 1", r2 - d1, idle_between);
    end
    vectors++;
    if (f2_rden != 64 || max_addr != 63) begin
      miscompares++;
      $display("[TB] FAIL b2b_addr: got reads=%0d max_addr=%0d, expected 64 63", f2_rden, max_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] drop_before;
    logic [12:0] at5;
    int pulses;
    pulses = 0; drop_before = 8'h00; at5 = 13'h1FFF;
    mem[0] = 32'h44332211; mem[1] = 32'h88776655;
    rd_len = 8'd7; rd_err = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) unread = 1'b1;
      if (c == 4) begin reset = 1'b1; unread = 1'b0; drop_before = drop_cnt; end
      if (c == 5) reset = 1'b0;
      #1;
      if (c >= 5 && (rd_done || rd_done_all || out_abort)) pulses++;
      if (c == 5) at5 = {out_valid, busy, drop_cnt, rd_addr[2:0]};
    end
    vectors++;
    if (drop_before !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_pre: got drop_cnt=%0d before reset, expected 1", drop_before);
    end
    vectors++;
    if (at5 !== 13'd0 || pulses != 0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got valid/busy/drop/addr=%h pulses=%0d, expected 0 0", at5, pulses);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; en_f = 1'b0; flush = 1'b0; unread = 1'b0;
    rd_len = 8'd0; rd_err = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    test_reset();
    en = 1'b1;
    test_basic();
    test_stall();
    test_drop();
    test_forward();
    test_flush_idle();
    test_flush_mid();
    test_flush_last();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cd_rx_drain.md
CD_RX_DRAIN -- requirements
Module: cd_rx_drain

Interface
REQ-001 Parameter LEN_PLUS1, default 1, meaning frame byte count = rd_len+1 (1..256); 0 means count = rd_len (0..255).
REQ-002 Parameter DROP_ERR, default 1, meaning 1 discards frames flagged rd_err and 0 forwards them marked out_err.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 en  in  1  drain enable; level-sensitive.
REQ-006 flush  in  1  one-cycle request to discard all buffered frames.
REQ-007 unread  in  1  RX RAM has a frame at its read slot (registered by RAM).
REQ-008 rd_len  in  8  length field of current read frame.
REQ-009 rd_err  in  1  error flag of current read frame.
REQ-010 rd_word  in  32  RAM read data, little-endian bytes, valid 1 cycle after rd_en.
REQ-011 rd_addr  out  6  RAM word address within current frame.
REQ-012 rd_en  out  1  RAM read strobe.
REQ-013 rd_done  out  1  one-cycle pulse releasing current frame.
REQ-014 rd_done_all  out  1  one-cycle pulse clearing the whole RAM.
REQ-015 out_byte  out  8  stream data.
REQ-016 out_valid / out_ready  out / in  1 / 1  stream handshake; transfer when both high.
REQ-017 out_first, out_last, out_err  out  1 each  first byte, last byte, frame-error marker; qualified by out_valid.
REQ-018 out_abort  out  1  one-cycle pulse: frame in progress truncated by flush.
REQ-019 busy  out  1  state is not IDLE.
REQ-020 drop_cnt  out  8  count of frames discarded for rd_err; wraps 255->0.

Function
REQ-021 States: IDLE, SETTLE, FETCH, WAIT, SEND, DONE.
REQ-022 IDLE: en=1 and unread=1 -> latch rd_len, rd_err; compute 9-bit count n; go FETCH with rd_addr=0, byte index 0.
REQ-023 IDLE entry decision: rd_err=1 and DROP_ERR=1, or n=0 -> go DONE directly, no bytes emitted; drop_cnt increments only for the rd_err case.
REQ-024 FETCH: rd_en=1 for exactly one cycle at rd_addr -> WAIT; WAIT: capture rd_word into hold register -> SEND.
REQ-025 SEND: out_byte = hold byte (index mod 4); out_valid=1; out_first=1 only on frame byte 0; out_last=1 only on byte n-1; out_err = latched rd_err.
REQ-026 SEND holds out_byte/flags stable while out_valid=1 and out_ready=0.
REQ-027 On transfer of byte n-1 -> DONE; on transfer of byte with index mod 4 = 3 (not last) -> rd_addr+1, FETCH.
REQ-028 DONE: rd_done=1 for one cycle -> SETTLE.
REQ-029 SETTLE lasts exactly 2 cycles (RAM unread/rd_len refresh latency) -> IDLE; unread is not sampled in SETTLE.
REQ-030 Throughput: one byte per cycle within a word under continuous out_ready; 2-cycle gap (FETCH, WAIT) between words.
REQ-031 en deassertion mid-frame has no effect until DONE; IDLE then stays until en=1.
REQ-032 flush in any state: rd_done_all=1 next cycle, rd_done suppressed, out_valid=0 next cycle, state -> SETTLE.
REQ-033 flush while in FETCH/WAIT/SEND (frame started): out_abort=1 with rd_done_all; flush in IDLE/DONE/SETTLE: no out_abort.
REQ-034 flush coincident with final byte transfer: transfer counts, rd_done not issued, rd_done_all issued, no out_abort.
REQ-035 rd_done and rd_done_all never asserted in the same cycle; rd_en never asserted outside FETCH.
REQ-036 n=256 (LEN_PLUS1=1, rd_len=255): 64 words, rd_addr 0..63, no address overflow.

Reset
REQ-037 reset=1 at a clock edge -> state IDLE, all outputs 0, drop_cnt=0, hold register cleared; overrides flush and en.
REQ-038 reset mid-frame: no rd_done, rd_done_all or out_abort issued; RAM state is left to the RAM's own reset.

Verification
REQ-039 rd_len=4, LEN_PLUS1=1, out_ready=1, rd_word0=0x44332211, word1=0x000000AA -> bytes 11,22,33,44,AA; first on 11, last on AA; one rd_done; rd_addr 0 then 1.
REQ-040 Same frame, out_ready toggled 1/0 every cycle -> identical byte order, output stable during stalls, rd_done only after AA accepted.
REQ-041 DROP_ERR=1, rd_err=1, rd_len=9 -> zero out_valid cycles, rd_en never asserted, one rd_done, drop_cnt 0->1; DROP_ERR=0 -> 10 bytes with out_err=1.
REQ-042 flush after 2 of 8 bytes transferred -> out_valid low next cycle, rd_done_all and out_abort one-cycle pulses, no rd_done, busy low 3 cycles later.
REQ-043 Two back-to-back frames (rd_len=0 then 255, LEN_PLUS1=1) -> 1 byte then 256 bytes, rd_addr reaches 63, exactly 2 SETTLE cycles between frames.
REQ-044 Assert reset during SEND -> next cycle out_valid=0, busy=0, drop_cnt=0, no done pulses.
